// File: rtl/ep_paritychk_rx.sv
// ---------------------------------------------------------------------------
// ep_paritychk_rx
//   Receive end of the parity-protected serial link. It deserialises frames
//   (start bit, DATA_W data bits LSB-first, parity bit, stop bit) and checks
//   even or odd parity. Each received word is presented on a valid/ready
//   output port together with a parity-error tag.
//
// Optional feature macro: PARITY_ERR_CNT_EN
//   When defined, the CNT_W parameter and the err_clr/err_cnt ports exist.
//   err_cnt is a saturating count of parity-bad delivered words, framing
//   errors and overrun drops. When undefined, that logic is absent.
//
// Parameters
//   DATA_W       data bits per frame (>= 1)
//   CNT_W        error counter width (PARITY_ERR_CNT_EN only)
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   rx_bit_en    bit-time strobe; the line is sampled only when high
//   rx_line      serial line, idles high
//   odd_sel      0 = even parity expected, 1 = odd parity expected
//   out_data     received word
//   out_par_err  parity-error tag for out_data, qualified by out_valid
//   out_valid    word available
//   out_ready    consumer accepts when out_valid & out_ready
//   frm_err      1-cycle pulse: stop bit sampled low, frame discarded
//   ovr_err      1-cycle pulse: good frame dropped, output still occupied
//   err_clr      synchronous clear of err_cnt (PARITY_ERR_CNT_EN only)
//   err_cnt      saturating error count (PARITY_ERR_CNT_EN only)
// ---------------------------------------------------------------------------
module ep_paritychk_rx #(
    parameter int DATA_W = 9
`ifdef PARITY_ERR_CNT_EN
    ,
    parameter int CNT_W  = 8
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_bit_en,
    input  logic              rx_line,
    input  logic              odd_sel,
    output logic [DATA_W-1:0] out_data,
    output logic              out_par_err,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              frm_err,
    output logic              ovr_err
`ifdef PARITY_ERR_CNT_EN
    ,
    input  logic              err_clr,
    output logic [CNT_W-1:0]  err_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } state_t;

    // The bit counter needs at least one bit, even when DATA_W is 1.
    localparam int                BIT_CW   = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [BIT_CW-1:0] BIT_LAST = BIT_CW'(DATA_W - 1);
    localparam logic [BIT_CW-1:0] BIT_ONE  = BIT_CW'(1);

    // Parity is bad when data plus parity bit do not give the selected sense.
    function automatic logic calc_par_bad(input logic [DATA_W-1:0] data,
                                          input logic              par_bit,
                                          input logic              odd);
        return ((^data) ^ par_bit) != odd;
    endfunction

    state_t              state_q, state_d;
    logic [BIT_CW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic                par_bit_q, par_bit_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic                out_par_err_q, out_par_err_d;
    logic                out_valid_q, out_valid_d;
    logic                frm_err_q, frm_err_d;
    logic                ovr_err_q, ovr_err_d;
    logic                stop_strobe_s;
    logic                par_bad_s;
    logic                load_s;

    // Frame FSM: walks start, data, parity and stop on bit strobes only.
    always_comb begin
        state_d       = state_q;
        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
        par_bit_d     = par_bit_q;
        stop_strobe_s = 1'b0;
        if (rx_bit_en) begin
            case (state_q)
                ST_IDLE: begin
                    if (!rx_line) begin
                        state_d   = ST_DATA;
                        bit_cnt_d = '0;
                    end else begin
                        state_d   = ST_IDLE;
                    end
                end
                ST_DATA: begin
                    // Bits arrive LSB first, so each one lands at its counter index.
                    shift_d[bit_cnt_q] = rx_line;
                    if (bit_cnt_q == BIT_LAST) begin
                        state_d   = ST_PARITY;
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_ONE;
                    end
                end
                ST_PARITY: begin
                    par_bit_d = rx_line;
                    state_d   = ST_STOP;
                end
                ST_STOP: begin
                    stop_strobe_s = 1'b1;
                    state_d       = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Output slot: load on a good stop bit if the slot is free or draining now.
    always_comb begin
        par_bad_s     = calc_par_bad(shift_q, par_bit_q, odd_sel);
        load_s        = 1'b0;
        out_data_d    = out_data_q;
        out_par_err_d = out_par_err_q;
        out_valid_d   = out_valid_q & ~out_ready;
        frm_err_d     = 1'b0;
        ovr_err_d     = 1'b0;
        if (stop_strobe_s) begin
            if (!rx_line) begin
                frm_err_d = 1'b1;
            end else if (!out_valid_q || out_ready) begin
                load_s        = 1'b1;
                out_data_d    = shift_q;
                out_par_err_d = par_bad_s;
                out_valid_d   = 1'b1;
            end else begin
                ovr_err_d = 1'b1;
            end
        end else begin
            load_s = 1'b0;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            par_bit_q     <= 1'b0;
            out_data_q    <= '0;
            out_par_err_q <= 1'b0;
            out_valid_q   <= 1'b0;
            frm_err_q     <= 1'b0;
            ovr_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            par_bit_q     <= par_bit_d;
            out_data_q    <= out_data_d;
            out_par_err_q <= out_par_err_d;
            out_valid_q   <= out_valid_d;
            frm_err_q     <= frm_err_d;
            ovr_err_q     <= ovr_err_d;
        end
    end

    assign out_data    = out_data_q;
    assign out_par_err = out_par_err_q;
    assign out_valid   = out_valid_q;
    assign frm_err     = frm_err_q;
    assign ovr_err     = ovr_err_q;

`ifdef PARITY_ERR_CNT_EN
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic             err_evt_s;

    // Error counter: at most one event per frame; clear beats increment.
    always_comb begin
        err_evt_s = frm_err_d | ovr_err_d | (load_s & par_bad_s);
        if (err_clr) begin
            err_cnt_d = '0;
        end else if (err_evt_s && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + CNT_ONE;
        end else begin
            err_cnt_d = err_cnt_q;
        end
    end

    // Error counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`endif

endmodule
